// File: rtl/sp_ram_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_pkg
//  Shared types for the configurable single-port RAM (sp_ram_cfg) and its
//  clear controller.
//   rdw_mode_e  : read-during-write behaviour of the read port
//   clr_state_e : clear-engine FSM states
// -----------------------------------------------------------------------------
package sp_ram_pkg;

   typedef enum logic [1:0] {
      RDW_READ_FIRST  = 2'd0,
      RDW_WRITE_FIRST = 2'd1,
      RDW_NO_CHANGE   = 2'd2
   } rdw_mode_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } clr_state_e;

endpackage

// File: rtl/sp_ram_clear_ctrl.sv
// -----------------------------------------------------------------------------
// sp_ram_clear_ctrl
//  Post-reset clear engine for sp_ram_cfg. Walks a pointer over every word,
//  writing zero, and muxes that clear write ahead of the user port.
//  Ports:
//   clk, i_rst          clock, synchronous active-high reset
//   i_en/i_we/i_be      user access request
//   i_addr/i_data       user address / write data
//   o_acc               user access accepted this cycle
//   o_wr                array write strobe (clear or user write)
//   o_be/o_addr/o_data  muxed write lane enables, address, data
//   o_busy              clear in progress
// -----------------------------------------------------------------------------
module sp_ram_clear_ctrl
   import sp_ram_pkg::*;
#(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 8,
   parameter int NB           = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [NB-1:0]     i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_acc,
   output logic              o_wr,
   output logic [NB-1:0]     o_be,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy
);

   localparam logic [ADDR_W-1:0] P_LAST      = '1;
   localparam clr_state_e        P_RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

   clr_state_e        r_state;
   clr_state_e        w_state_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_next;
   logic              w_clr_we;
   logic              w_clr_wr;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= P_RST_STATE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_clr_we     = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_clr_we   = 1'b1;
            w_ptr_next = r_ptr + 1'b1;
            // The edge that zeroes the last word also releases busy.
            if (r_ptr == P_LAST) begin
               w_state_next = ST_RUN;
            end
         end
         default: begin
            w_state_next = r_state;
         end
      endcase
   end

   // Reset takes priority: no clear write or user access lands while rst=1.
   assign w_clr_wr = w_clr_we & ~i_rst;
   assign o_acc    = i_en & (r_state == ST_RUN) & ~i_rst;
   assign o_wr     = w_clr_wr | (o_acc & i_we);
   assign o_be     = w_clr_wr ? {NB{1'b1}} : i_be;
   assign o_addr   = (r_state == ST_CLEAR) ? r_ptr : i_addr;
   assign o_data   = w_clr_wr ? '0 : i_data;
   assign o_busy   = (r_state == ST_CLEAR);

endmodule

// File: rtl/sp_ram_cfg.sv
// -----------------------------------------------------------------------------
// sp_ram_cfg
//  Parametrised single-port synchronous RAM with byte-lane writes, selectable
//  read-during-write behaviour, optional output register and a post-reset
//  zero-fill engine.
//  Ports:
//   clk, rst       clock, synchronous active-high reset
//   en, we, be     access enable, write enable, per-lane write enables
//   addr, data     word address (modulo DEPTH), write data
//   q, q_valid     read data, one-cycle pulse when q carries a new result
//   busy           clear in progress; accesses ignored
// -----------------------------------------------------------------------------
module sp_ram_cfg
   import sp_ram_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 6,
   parameter int BYTE_W       = 8,
   parameter int RDW_MODE     = 0,
   parameter int OUT_REG      = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     we,
   input  logic [DATA_W/BYTE_W-1:0] be,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        data,
   output logic [DATA_W-1:0]        q,
   output logic                     q_valid,
   output logic                     busy
);

   localparam int        NB     = DATA_W / BYTE_W;
   localparam int        DEPTH  = 1 << ADDR_W;
   localparam rdw_mode_e P_MODE = rdw_mode_e'(RDW_MODE[1:0]);

   if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
      $error("sp_ram_cfg: DATA_W must be a multiple of BYTE_W");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_acc;
   logic              w_wr;
   logic [NB-1:0]     w_be;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] w_merged;
   logic [DATA_W-1:0] w_rd_val;
   logic              w_rd_fire;
   logic [DATA_W-1:0] r_q1;
   logic              r_v1;

   sp_ram_clear_ctrl #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .NB           (NB),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear (
      .clk    (clk),
      .i_rst  (rst),
      .i_en   (en),
      .i_we   (we),
      .i_be   (be),
      .i_addr (addr),
      .i_data (data),
      .o_acc  (w_acc),
      .o_wr   (w_wr),
      .o_be   (w_be),
      .o_addr (w_addr),
      .o_data (w_wdata),
      .o_busy (busy)
   );

   // Array: byte-lane write port, read data registered below.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) begin
               r_mem[w_addr][i*BYTE_W +: BYTE_W] <= w_wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign w_rd_word = r_mem[w_addr];

   // Post-write view of the addressed word, used for WRITE_FIRST reads.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merged[gi*BYTE_W +: BYTE_W] = w_be[gi] ? w_wdata[gi*BYTE_W +: BYTE_W]
                                                      : w_rd_word[gi*BYTE_W +: BYTE_W];
   end

   // NO_CHANGE suppresses the read result of a write entirely.
   assign w_rd_fire = w_acc & ~((P_MODE == RDW_NO_CHANGE) & we);
   assign w_rd_val  = ((P_MODE == RDW_WRITE_FIRST) && we) ? w_merged : w_rd_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= w_rd_fire;
         if (w_rd_fire) begin
            r_q1 <= w_rd_val;
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_q2;
      logic              r_v2;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_q2 <= '0;
            r_v2 <= 1'b0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_q2 <= r_q1;
            end
         end
      end

      assign q       = r_q2;
      assign q_valid = r_v2;
   end else begin : g_no_out_reg
      assign q       = r_q1;
      assign q_valid = r_v1;
   end

endmodule
